// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port, variable-latency memory between the instruction
//   fetch port (IF stage) and the load/store port (MEM stage). Data accesses
//   have priority, but after STARVE_MAX consecutive data grants with a fetch
//   pending, the fetch is granted. Each access walks IDLE -> BUSY_x -> RESP,
//   so an access takes at least three cycles from request to ack.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   if_req/if_addr           fetch request (held until if_ack) and PC
//   if_rdata/if_ack          fetched word, valid during the one-cycle if_ack
//   if_stall                 if_req & ~if_ack, for the hazard unit
//   d_req/d_we/d_addr/d_wdata  load/store request (held until d_ack)
//   d_rdata/d_ack            load data, valid during the one-cycle d_ack
//   d_stall                  d_req & ~d_ack, for the hazard unit
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ready      memory response, only sampled in BUSY_*
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       grant_d;

    // Data wins unless a fetch is pending and has already been passed over
    // STARVE_LIM times in a row.
    assign grant_d  = d_req & (~if_req | (starve_cnt < STARVE_LIM));

    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        // Only a data grant that bypasses a waiting fetch counts.
                        if (!if_req)
                            starve_cnt <= '0;
                        else if (starve_cnt < STARVE_LIM)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (if_req) begin
                        state      <= BUSY_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        d_ack   <= 1'b1;
                        // A store's ack leaves the last load result in place.
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .d_stall  (d_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    bit [255:0]  valid = '0;
    int unsigned wait_cycles = 0;
    int unsigned wcnt = 0;

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        case (idx)
            8'd4:    return 32'h00500093;
            8'd8:    return 32'h00A00113;
            8'd12:   return 32'h00000013;
            8'd20:   return 32'hCAFE0001;
            8'd36:   return 32'h0BADF00D;
            default: return {4{idx}};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!mem_req || mem_ready) begin
            mem_ready <= 1'b0;
            wcnt      <= 0;
        end else if (wcnt == wait_cycles) begin
            mem_ready <= 1'b1;
            if (mem_we) begin
                mem[mem_addr[9:2]]   <= mem_wdata;
                valid[mem_addr[9:2]] <= 1'b1;
                mem_rdata            <= 32'hA5A5A5A5;
            end else begin
                mem_rdata <= valid[mem_addr[9:2]] ? mem[mem_addr[9:2]]
                                                  : init_word(mem_addr[9:2]);
            end
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    // ---------------- monitors and scoreboard ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
    } grant_t;

    grant_t      glog[$];
    logic        prev_req = 1'b0;
    int          if_ack_cnt = 0;
    int          d_ack_cnt = 0;
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] last_load = 32'h0;

    always @(negedge clk) begin
        if (mem_req && !prev_req)
            glog.push_back({mem_we, mem_addr});
        prev_req = mem_req;
        if (if_ack) if_ack_cnt++;
        if (d_ack)  d_ack_cnt++;
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // ---------------- T1: reset values and reset mid-BUSY_D ----------------
    task automatic test_reset;
        int k;
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (2) step;
        n_cmp++;
        if ({mem_req, mem_we, if_ack, d_ack} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, if_ack, d_ack});
        end
        n_cmp++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0 0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got if %h d %h want 0 0", if_rdata, d_rdata);
        end
        n_cmp++;
        if (dut.starve_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt);
        end

        rst = 1'b0;
        step;
        wait_cycles = 5;
        d_we = 1; d_addr = 32'h60; d_wdata = 32'h11; d_req = 1;
        for (k = 0; k < 10 && !mem_req; k++) step;
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL t1_grant: got mem_req %b want 1 within 10 cycles", mem_req);
        end
        n_cmp++;
        if (d_stall !== 1'b1) begin
            n_fail++; $display("FAIL t1_d_stall: got %b want 1", d_stall);
        end
        step;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, d_ack, if_ack} !== 3'b000) begin
            n_fail++; $display("FAIL t1_async_rst: got %b want 000", {mem_req, d_ack, if_ack});
        end
        repeat (2) step;
        d_req = 0;
        rst = 1'b0;
        repeat (8) step;
        n_cmp++;
        if (d_ack_cnt !== 0 || if_ack_cnt !== 0) begin
            n_fail++; $display("FAIL t1_stray_ack: got d %0d i %0d want 0 0", d_ack_cnt, if_ack_cnt);
        end
        n_cmp++;
        if (mem_req !== 1'b0 || valid[24] !== 1'b0) begin
            n_fail++; $display("FAIL t1_abandoned: got mem_req %b written %b want 0 0", mem_req, valid[24]);
        end
    endtask

    // ---------------- T2: single fetch, one wait state ----------------
    task automatic test_single_fetch;
        int     cyc;
        bit     got;
        bit     we_bad;
        int     base;
        grant_t g;
        wait_cycles = 1;
        glog.delete();
        base = if_ack_cnt;
        exp_i.push_back(32'h00500093);
        if_addr = 32'h10; if_req = 1;
        cyc = 0; got = 0; we_bad = 0;
        while (!got && cyc < 20) begin
            step; cyc++;
            if (mem_we !== 1'b0) we_bad = 1;
            if (if_ack === 1'b1) begin
                got = 1;
                n_cmp++;
                if (if_rdata !== exp_i[0]) begin
                    n_fail++; $display("FAIL t2_rdata: got %h want %h", if_rdata, exp_i[0]);
                end
                void'(exp_i.pop_front());
                n_cmp++;
                if (cyc !== 4) begin
                    n_fail++; $display("FAIL t2_latency: got %0d want 4", cyc);
                end
                if_req = 0;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++; $display("FAIL t2_timeout: got no if_ack want ack in 20 cycles");
        end
        n_cmp++;
        if (we_bad) begin
            n_fail++; $display("FAIL t2_mem_we: got 1 want 0 throughout");
        end
        repeat (4) step;
        n_cmp++;
        if (if_ack_cnt - base !== 1) begin
            n_fail++; $display("FAIL t2_ack_count: got %0d want 1", if_ack_cnt - base);
        end
        g = glog.size() > 0 ? glog[0] : '0;
        n_cmp++;
        if (glog.size() !== 1 || g.we !== 1'b0 || g.addr !== 32'h10) begin
            n_fail++; $display("FAIL t2_grant: got n=%0d we=%b addr=%h want 1 0 00000010", glog.size(), g.we, g.addr);
        end
    endtask

    // ---------------- T3: simultaneous store and fetch ----------------
    task automatic test_collision;
        int     cyc;
        bit     d_done;
        bit     i_done;
        bit     stall_bad;
        grant_t g;
        wait_cycles = 0;
        glog.delete();
        exp_d.push_back(last_load);
        exp_i.push_back(32'h00A00113);
        if_addr = 32'h20; if_req = 1;
        d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_req = 1;
        cyc = 0; d_done = 0; i_done = 0; stall_bad = 0;
        while (!(d_done && i_done) && cyc < 30) begin
            step; cyc++;
            if (!i_done && if_stall !== (cyc != 7)) stall_bad = 1;
            if (d_ack === 1'b1) begin
                d_done = 1;
                n_cmp++;
                if (d_rdata !== exp_d[0] || cyc !== 3) begin
                    n_fail++; $display("FAIL t3_store_ack: got rdata %h cyc %0d want %h 3", d_rdata, cyc, exp_d[0]);
                end
                void'(exp_d.pop_front());
                d_req = 0;
            end
            if (if_ack === 1'b1) begin
                i_done = 1;
                n_cmp++;
                if (if_rdata !== exp_i[0] || cyc !== 7) begin
                    n_fail++; $display("FAIL t3_fetch_ack: got rdata %h cyc %0d want %h 7", if_rdata, cyc, exp_i[0]);
                end
                void'(exp_i.pop_front());
                if_req = 0;
            end
        end
        if (!(d_done && i_done)) begin
            n_cmp++; n_fail++; $display("FAIL t3_timeout: got d %b i %b want both acks", d_done, i_done);
        end
        n_cmp++;
        if (stall_bad) begin
            n_fail++; $display("FAIL t3_if_stall: got early drop or late hold want high until if_ack");
        end
        g = glog.size() > 0 ? glog[0] : '0;
        n_cmp++;
        if (glog.size() !== 2 || g.we !== 1'b1 || g.addr !== 32'h40) begin
            n_fail++; $display("FAIL t3_first_grant: got n=%0d we=%b addr=%h want 2 1 00000040", glog.size(), g.we, g.addr);
        end
        g = glog.size() > 1 ? glog[1] : '0;
        n_cmp++;
        if (g.we !== 1'b0 || g.addr !== 32'h20) begin
            n_fail++; $display("FAIL t3_second_grant: got we=%b addr=%h want 0 00000020", g.we, g.addr);
        end
        n_cmp++;
        if (mem[16] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL t3_store_data: got %h want deadbeef", mem[16]);
        end
    endtask

    // ---------------- T4: starvation cap ----------------
    task automatic test_starvation;
        int         cyc;
        int         d_done;
        bit         i_done;
        logic [3:0] max_cnt;
        grant_t     g;
        logic [31:0] want_addr;
        wait_cycles = 0;
        glog.delete();
        exp_d.push_back(32'hCAFE0001);
        exp_i.push_back(32'h00000013);
        if_addr = 32'h30; if_req = 1;
        d_we = 0; d_addr = 32'h50; d_req = 1;
        cyc = 0; d_done = 0; i_done = 0; max_cnt = 0;
        while (!(d_done == 5 && i_done) && cyc < 80) begin
            step; cyc++;
            if (!i_done && dut.starve_cnt > max_cnt) max_cnt = dut.starve_cnt;
            if (d_ack === 1'b1) begin
                d_done++;
                n_cmp++;
                if (d_rdata !== exp_d[0]) begin
                    n_fail++; $display("FAIL t4_load_%0d: got %h want %h", d_done, d_rdata, exp_d[0]);
                end
                void'(exp_d.pop_front());
                if (d_done == 5) d_req = 0;
                else exp_d.push_back(32'hCAFE0001);
            end
            if (if_ack === 1'b1) begin
                i_done = 1;
                n_cmp++;
                if (if_rdata !== exp_i[0]) begin
                    n_fail++; $display("FAIL t4_fetch: got %h want %h", if_rdata, exp_i[0]);
                end
                void'(exp_i.pop_front());
                n_cmp++;
                if (dut.starve_cnt !== 4'd0) begin
                    n_fail++; $display("FAIL t4_cnt_clear: got %0d want 0", dut.starve_cnt);
                end
                if_req = 0;
            end
        end
        if (!(d_done == 5 && i_done)) begin
            n_cmp++; n_fail++; $display("FAIL t4_timeout: got d %0d i %b want 5 1", d_done, i_done);
        end
        n_cmp++;
        if (max_cnt !== 4'd4) begin
            n_fail++; $display("FAIL t4_cnt_peak: got %0d want 4", max_cnt);
        end
        n_cmp++;
        if (glog.size() !== 6) begin
            n_fail++; $display("FAIL t4_grant_count: got %0d want 6", glog.size());
        end
        for (int i = 0; i < glog.size() && i < 6; i++) begin
            g = glog[i];
            want_addr = (i == 4) ? 32'h30 : 32'h50;
            n_cmp++;
            if (g.addr !== want_addr || g.we !== 1'b0) begin
                n_fail++; $display("FAIL t4_grant_%0d: got addr %h want %h", i, g.addr, want_addr);
            end
        end
        last_load = 32'hCAFE0001;
    endtask

    // ---------------- T5: store then load, zero wait ----------------
    task automatic test_load_data;
        int cyc;
        bit got;
        wait_cycles = 0;
        d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678; d_req = 1;
        exp_d.push_back(last_load);
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            step; cyc++;
            if (d_ack === 1'b1) begin
                got = 1;
                n_cmp++;
                if (d_rdata !== exp_d[0]) begin
                    n_fail++; $display("FAIL t5_store_keeps_rdata: got %h want %h", d_rdata, exp_d[0]);
                end
                void'(exp_d.pop_front());
                d_req = 0;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++; $display("FAIL t5_store_timeout: got no d_ack want ack in 20 cycles");
        end
        step;
        d_we = 0; d_wdata = 32'h0; d_req = 1;
        exp_d.push_back(32'h12345678);
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            step; cyc++;
            if (d_ack === 1'b1) begin
                got = 1;
                n_cmp++;
                if (d_rdata !== exp_d[0] || cyc !== 3) begin
                    n_fail++; $display("FAIL t5_load: got %h cyc %0d want %h 3", d_rdata, cyc, exp_d[0]);
                end
                void'(exp_d.pop_front());
                d_req = 0;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++; $display("FAIL t5_load_timeout: got no d_ack want ack in 20 cycles");
        end
        last_load = 32'h12345678;
    endtask

    // ---------------- T6: request dropped during BUSY_D ----------------
    task automatic test_abandon;
        int k;
        int base;
        bit got;
        bit hold_bad;
        wait_cycles = 3;
        base = d_ack_cnt;
        d_we = 0; d_addr = 32'h90; d_req = 1;
        exp_d.push_back(32'h0BADF00D);
        for (k = 0; k < 10 && !mem_req; k++) step;
        step;
        d_req = 0; d_addr = 32'hFFFF_FFF0;
        got = 0; hold_bad = 0;
        for (k = 0; k < 20 && !got; k++) begin
            step;
            if (d_ack === 1'b1) begin
                got = 1;
                n_cmp++;
                if (d_rdata !== exp_d[0]) begin
                    n_fail++; $display("FAIL t6_rdata: got %h want %h", d_rdata, exp_d[0]);
                end
                void'(exp_d.pop_front());
            end else if (mem_req !== 1'b1 || mem_addr !== 32'h90) begin
                hold_bad = 1;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++; $display("FAIL t6_timeout: got no d_ack want ack in 20 cycles");
        end
        n_cmp++;
        if (hold_bad) begin
            n_fail++; $display("FAIL t6_hold: got mem_req/mem_addr changed want held until mem_ready");
        end
        repeat (5) step;
        n_cmp++;
        if (d_ack_cnt - base !== 1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL t6_single_ack: got acks %0d mem_req %b want 1 0", d_ack_cnt - base, mem_req);
        end
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_collision;
        test_starvation;
        test_load_data;
        test_abandon;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
